mines_board_engine: RTL and testbench



---
 rtl/mines_pkg.sv | 42 ++++
 rtl/mines_lfsr16.sv | 22 ++
 rtl/mines_board_engine.sv | 179 +++++++++++++++++
 tb/tb_mines_board_engine.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mines_pkg.sv
// Shared types and display codes for the minesweeper board engine and its renderer.
package mines_pkg;

   typedef enum logic [1:0] {
      GS_IDLE = 2'd0,
      GS_PLAY = 2'd1,
      GS_LOST = 2'd2,
      GS_WON  = 2'd3
   } game_state_t;

   localparam logic [9:0] CODE_EMPTY    = 10'h000;
   localparam logic [9:0] CODE_SEL      = 10'h001;
   localparam logic [9:0] CODE_GRASS    = 10'h002;
   localparam logic [9:0] CODE_BOMB     = 10'h004;
   localparam logic [9:0] CODE_BOMB_HID = 10'h006;
   localparam logic [9:0] CODE_FLAG     = 10'h008;
   localparam logic [9:0] CODE_NUM_BASE = 10'h010;

   typedef struct packed {
      logic       bomb;
      logic       revealed;
      logic       flag;
      logic [3:0] count;
   } cell_t;

   // Display code of one cell without the cursor highlight; earlier tests win.
   function automatic logic [9:0] cell_code(input cell_t c);
      if (c.revealed && c.bomb)
         return CODE_BOMB;
      else if (c.revealed && (c.count == 4'd0))
         return CODE_EMPTY;
      else if (c.revealed)
         return ({6'd0, c.count} << 6) | CODE_NUM_BASE;
      else if (c.flag)
         return CODE_FLAG;
      else if (c.bomb)
         return CODE_BOMB_HID;
      else
         return CODE_GRASS;
   endfunction

endpackage

// File: rtl/mines_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the mine placement source.
module mines_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] lfsr
);

   logic feedback;

   assign feedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // Shift right every cycle, new bit enters at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= SEED;
      else
         lfsr <= {feedback, lfsr[15:1]};
   end

endmodule

// File: rtl/mines_board_engine.sv
// Minesweeper game-state engine: owns the 8x8 board, the cursor and win/lose
// detection, and serves registered per-cell display codes to the renderer.
module mines_board_engine
   import mines_pkg::*;
#(
   parameter int          FILAS    = 8,
   parameter int          COLUMNAS = 8,
   parameter int          MINES    = 10,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_reveal,
   input  logic       btn_flag,
   input  logic [2:0] rd_row,
   input  logic [2:0] rd_col,
   output logic [9:0] rd_code,
   output logic [1:0] game_state,
   output logic       busy
);

   typedef enum logic [2:0] {S_IDLE, S_PLACE, S_PLAY, S_COUNT, S_LOST, S_WON} state_t;

   localparam int                NCELLS     = FILAS * COLUMNAS;
   localparam logic [6:0]        MINES_W    = 7'(MINES);
   localparam logic [6:0]        SAFE_CELLS = 7'(NCELLS - MINES);
   localparam logic [2:0]        ROW_LAST   = 3'(FILAS - 1);
   localparam logic [2:0]        COL_LAST   = 3'(COLUMNAS - 1);
   localparam logic signed [4:0] ROW_MAX    = 5'(FILAS - 1);
   localparam logic signed [4:0] COL_MAX    = 5'(COLUMNAS - 1);

   state_t            state;
   game_state_t       gs_q;
   cell_t             cells [NCELLS];
   logic [2:0]        cur_row, cur_col, tgt_row, tgt_col, nb_idx;
   logic [3:0]        nb_acc, nb_total;
   logic [6:0]        placed_cnt, revealed_cnt;
   logic [15:0]       lfsr;
   logic [5:0]        cand_idx, cur_idx, tgt_idx, nb_flat;
   logic signed [4:0] nb_row, nb_col;
   logic              nb_on_board, nb_is_bomb, sel_hit;
   logic [9:0]        rd_code_p1;
   logic              unused_lfsr_bits;

   // Row offset of neighbour i in scan order NW,N,NE,W,E,SW,S,SE.
   function automatic logic signed [4:0] nb_dr(input logic [2:0] i);
      if (i < 3'd3)      return -5'sd1;
      else if (i < 3'd5) return 5'sd0;
      else               return 5'sd1;
   endfunction

   // Column offset of neighbour i in the same scan order.
   function automatic logic signed [4:0] nb_dc(input logic [2:0] i);
      case (i)
         3'd0, 3'd3, 3'd5: return -5'sd1;
         3'd1, 3'd6:       return 5'sd0;
         default:          return 5'sd1;
      endcase
   endfunction

   mines_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk  (clk),
      .rst_n(rst_n),
      .lfsr (lfsr)
   );

   assign unused_lfsr_bits = ^lfsr[15:6];
   assign cand_idx    = lfsr[5:0];
   assign cur_idx     = {cur_row, cur_col};
   assign tgt_idx     = {tgt_row, tgt_col};
   assign nb_row      = $signed({2'b00, tgt_row}) + nb_dr(nb_idx);
   assign nb_col      = $signed({2'b00, tgt_col}) + nb_dc(nb_idx);
   assign nb_on_board = (nb_row >= 5'sd0) && (nb_row <= ROW_MAX) &&
                        (nb_col >= 5'sd0) && (nb_col <= COL_MAX);
   assign nb_flat     = {nb_row[2:0], nb_col[2:0]};
   assign nb_is_bomb  = nb_on_board && cells[nb_flat].bomb;
   assign nb_total    = nb_acc + {3'b000, nb_is_bomb};
   assign sel_hit     = (gs_q == GS_PLAY) && (rd_row == cur_row) && (rd_col == cur_col);
   assign game_state  = gs_q;
   assign rd_code     = rd_code_p1;

   // Game FSM: placement, cursor, flag/reveal handling, serial neighbour count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         gs_q         <= GS_IDLE;
         busy         <= 1'b0;
         cur_row      <= 3'd0;
         cur_col      <= 3'd0;
         tgt_row      <= 3'd0;
         tgt_col      <= 3'd0;
         nb_idx       <= 3'd0;
         nb_acc       <= 4'd0;
         placed_cnt   <= 7'd0;
         revealed_cnt <= 7'd0;
         for (int i = 0; i < NCELLS; i++) cells[i] <= '0;
      end else if (start) begin
         for (int i = 0; i < NCELLS; i++) cells[i] <= '0;
         placed_cnt   <= 7'd0;
         revealed_cnt <= 7'd0;
         state        <= S_PLACE;
         gs_q         <= GS_PLAY;
         busy         <= 1'b1;
      end else begin
         case (state)
            S_PLACE: begin
               if (!cells[cand_idx].bomb) begin
                  cells[cand_idx].bomb <= 1'b1;
                  placed_cnt           <= placed_cnt + 7'd1;
                  if (placed_cnt + 7'd1 == MINES_W) begin
                     state <= S_PLAY;
                     busy  <= 1'b0;
                  end
               end
            end
            S_PLAY: begin
               if (btn_up && !btn_down && (cur_row != 3'd0))
                  cur_row <= cur_row - 3'd1;
               else if (btn_down && !btn_up && (cur_row != ROW_LAST))
                  cur_row <= cur_row + 3'd1;
               if (btn_left && !btn_right && (cur_col != 3'd0))
                  cur_col <= cur_col - 3'd1;
               else if (btn_right && !btn_left && (cur_col != COL_LAST))
                  cur_col <= cur_col + 3'd1;

               if (btn_flag) begin
                  if (!cells[cur_idx].revealed)
                     cells[cur_idx].flag <= ~cells[cur_idx].flag;
               end else if (btn_reveal && !cells[cur_idx].revealed && !cells[cur_idx].flag) begin
                  if (cells[cur_idx].bomb) begin
                     for (int i = 0; i < NCELLS; i++)
                        if (cells[i].bomb) cells[i].revealed <= 1'b1;
                     state <= S_LOST;
                     gs_q  <= GS_LOST;
                  end else begin
                     tgt_row <= cur_row;
                     tgt_col <= cur_col;
                     nb_idx  <= 3'd0;
                     nb_acc  <= 4'd0;
                     state   <= S_COUNT;
                     busy    <= 1'b1;
                  end
               end
            end
            S_COUNT: begin
               nb_idx <= nb_idx + 3'd1;
               nb_acc <= nb_total;
               if (nb_idx == 3'd7) begin
                  cells[tgt_idx].count    <= nb_total;
                  cells[tgt_idx].revealed <= 1'b1;
                  revealed_cnt            <= revealed_cnt + 7'd1;
                  busy                    <= 1'b0;
                  if (revealed_cnt + 7'd1 == SAFE_CELLS) begin
                     state <= S_WON;
                     gs_q  <= GS_WON;
                  end else begin
                     state <= S_PLAY;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Renderer read port: code of the addressed cell, one cycle after the address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_code_p1 <= CODE_EMPTY;
      else
         rd_code_p1 <= cell_code(cells[{rd_row, rd_col}]) | (sel_hit ? CODE_SEL : CODE_EMPTY);
   end

endmodule

// File: tb/tb_mines_board_engine.sv
// Randomized self-checking bench for mines_board_engine against a board-level game model.
module tb_mines_board_engine;

   localparam int MINES = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       btn_reveal = 1'b0, btn_flag = 1'b0;
   logic [2:0] rd_row = 3'd0, rd_col = 3'd0;
   logic [9:0] rd_code;
   logic [1:0] game_state;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Game model: board contents, cursor, state (0 idle,1 play,2 lost,3 won)
   bit          m_bomb [64];
   bit          m_rev  [64];
   bit          m_flag [64];
   int          m_r, m_c, m_state, m_revcnt;
   logic [15:0] m_lfsr;

   mines_board_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_reveal(btn_reveal),
      .btn_flag  (btn_flag),
      .rd_row    (rd_row),
      .rd_col    (rd_col),
      .rd_code   (rd_code),
      .game_state(game_state),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   // Reference LFSR: free-running sequence, reset value 16'hACE1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int nbombs(input int r, input int c);
      int n = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8 && m_bomb[(r + dr) * 8 + c + dc])
               n++;
      return n;
   endfunction

   function automatic logic [9:0] exp_code(input int i);
      int r, c, n;
      logic [9:0] code;
      r = i / 8;
      c = i % 8;
      if (m_rev[i] && m_bomb[i]) code = 10'h004;
      else if (m_rev[i]) begin
         n = nbombs(r, c);
         code = (n == 0) ? 10'h000 : ((10'(n) << 6) | 10'h010);
      end
      else if (m_flag[i]) code = 10'h008;
      else if (m_bomb[i]) code = 10'h006;
      else                code = 10'h002;
      if (m_state == 1 && r == m_r && c == m_c) code = code | 10'h001;
      return code;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         m_bomb[i] = 1'b0;
         m_rev[i]  = 1'b0;
         m_flag[i] = 1'b0;
      end
      m_revcnt = 0;
   endtask

   // Placement: successive LFSR values after the start edge, duplicates retried.
   task automatic model_start(input logic [15:0] l, output int attempts);
      logic [15:0] v;
      int placed;
      model_clear();
      v = l;
      placed = 0;
      attempts = 0;
      while (placed < MINES) begin
         v = lfsr_step(v);
         attempts++;
         if (!m_bomb[v[5:0]]) begin
            m_bomb[v[5:0]] = 1'b1;
            placed++;
         end
      end
      m_state = 1;
   endtask

   // b = {up, down, left, right, flag, reveal}
   task automatic model_act(input logic [5:0] b, output int exp_busy);
      int idx;
      exp_busy = 0;
      if (m_state != 1) return;
      idx = m_r * 8 + m_c;
      if (b[1]) begin
         if (!m_rev[idx]) m_flag[idx] = !m_flag[idx];
      end else if (b[0] && !m_rev[idx] && !m_flag[idx]) begin
         if (m_bomb[idx]) begin
            for (int i = 0; i < 64; i++) if (m_bomb[i]) m_rev[i] = 1'b1;
            m_state = 2;
         end else begin
            m_rev[idx] = 1'b1;
            m_revcnt++;
            exp_busy = 8;
            if (m_revcnt == 64 - MINES) m_state = 3;
         end
      end
      if (b[5] != b[4]) m_r = b[5] ? ((m_r > 0) ? m_r - 1 : 0) : ((m_r < 7) ? m_r + 1 : 7);
      if (b[3] != b[2]) m_c = b[3] ? ((m_c > 0) ? m_c - 1 : 0) : ((m_c < 7) ? m_c + 1 : 7);
   endtask

   task automatic read_check(input int r, input int c, input string tag);
      rd_row = 3'(r);
      rd_col = 3'(c);
      @(negedge clk);
      check_eq(tag, 32'(rd_code), 32'(exp_code(r * 8 + c)));
   endtask

   task automatic check_board(input string tag, output int hidden);
      hidden = 0;
      for (int i = 0; i < 64; i++) begin
         read_check(i / 8, i % 8, $sformatf("%s_cell%0d", tag, i));
         if (rd_code[9:1] == 9'h003) hidden++;
      end
   endtask

   task automatic press_start();
      int a, n;
      model_start(m_lfsr, a);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         n++;
         @(negedge clk);
      end
      check_eq("place_busy_cycles", 32'(n), 32'(a));
      check_eq("play_state", 32'(game_state), 32'd1);
   endtask

   task automatic act(input logic [5:0] b, input bit inject);
      int eb, n;
      model_act(b, eb);
      {btn_up, btn_down, btn_left, btn_right, btn_flag, btn_reveal} = b;
      @(negedge clk);
      {btn_up, btn_down, btn_left, btn_right, btn_flag, btn_reveal} = 6'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         if (inject && n == 2) {btn_right, btn_down} = 2'b11;
         else                  {btn_right, btn_down} = 2'b00;
         n++;
         @(negedge clk);
      end
      {btn_right, btn_down} = 2'b00;
      check_eq("count_busy_cycles", 32'(n), 32'(eb));
      check_eq("game_state", 32'(game_state), 32'(m_state));
      read_check(m_r, m_c, "cursor_cell");
   endtask

   task automatic goto_cell(input int r, input int c);
      while (m_r < r) act(6'b010000, 1'b0);
      while (m_r > r) act(6'b100000, 1'b0);
      while (m_c < c) act(6'b000100, 1'b0);
      while (m_c > c) act(6'b001000, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_state"}, 32'(game_state), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_code"}, 32'(rd_code), 32'h000);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hb, pick, safe_idx;
      logic [5:0] b;
      model_clear();
      m_r = 0; m_c = 0; m_state = 0;

      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check_eq("idle_state", 32'(game_state), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 6; k++) act(6'($urandom_range(0, 63)), 1'b0);
      check_board("idle", hb);

      // Random games
      for (int g = 0; g < 6; g++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk);
         if (g == 2) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
         end
         press_start();
         check_board("placed", hb);
         check_eq("mine_count", 32'(hb), 32'(MINES));
         if (g == 0) begin
            safe_idx = 0;
            while (m_bomb[safe_idx] || (safe_idx == m_r * 8 + m_c)) safe_idx++;
            goto_cell(safe_idx / 8, safe_idx % 8);
            act(6'b000010, 1'b0);
            check_eq("flag_code", 32'(rd_code), 32'h009);
            act(6'b000001, 1'b0);
            check_eq("flag_blocks_reveal", 32'(rd_code), 32'h009);
            act(6'b000010, 1'b0);
            check_eq("unflag_code", 32'(rd_code), 32'h003);
         end
         for (int s = 0; s < 40 && m_state == 1; s++) begin
            pick = $urandom_range(0, 9);
            case (pick)
               5:       b = 6'b000010;
               6, 8:    b = 6'b000001;
               7:       b = 6'b000011;
               9:       b = {4'($urandom_range(0, 15)), 2'b01};
               default: b = {4'($urandom_range(0, 15)), 2'b00};
            endcase
            act(b, 1'($urandom_range(0, 1)));
            if (s % 10 == 9) check_board("mid", hb);
         end
         if (m_state != 1) begin
            check_board("over", hb);
            for (int k = 0; k < 4; k++) act(6'($urandom_range(0, 63)), 1'b0);
            check_board("frozen", hb);
         end
      end

      // Win: reveal every safe cell
      repeat ($urandom_range(0, 20)) @(negedge clk);
      press_start();
      for (int i = 0; i < 64; i++) begin
         if (!m_bomb[i]) begin
            goto_cell(i / 8, i % 8);
            if (m_revcnt == 64 - MINES - 1)
               check_eq("pre_win_state", 32'(game_state), 32'd1);
            act(6'b000001, 1'b0);
         end
      end
      check_eq("won_state", 32'(game_state), 32'd3);
      check_board("won", hb);
      for (int k = 0; k < 3; k++) act(6'($urandom_range(0, 63)), 1'b0);
      check_board("won_frozen", hb);

      // Asynchronous reset in the middle of a neighbour count
      press_start();
      safe_idx = 0;
      while (m_bomb[safe_idx]) safe_idx++;
      goto_cell(safe_idx / 8, safe_idx % 8);
      btn_reveal = 1'b1;
      @(negedge clk);
      btn_reveal = 1'b0;
      check_eq("mid_count_busy", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_clear();
      m_r = 0; m_c = 0; m_state = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_board("post_rst", hb);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
